// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared fetch-path widths, PC constants and fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : PC register and single-outstanding instruction fetch sequencer
//               feeding decode through a one-entry valid/ready buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int               XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEF),
    parameter logic [XLEN-1:0]  TRAP_PC  = XLEN'(riscv_pkg::TRAP_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc
);

    fetch_state_t    r_state;
    logic            r_kill;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_addr_q;
    logic            r_instr_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_instr_pc;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_unused;

    assign w_redirect = redirect_valid | trap;
    assign w_target   = trap ? TRAP_PC : {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused   = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_kill        <= 1'b0;
            r_pc          <= RESET_PC;
            r_addr_q      <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_gnt) begin
                        r_addr_q <= r_pc;
                        r_pc     <= r_pc + XLEN'(PC_STEP);
                        r_state  <= WAIT;
                        // A redirect racing the grant leaves a stale request in flight.
                        r_kill   <= w_redirect;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_kill <= 1'b0;
                        if (r_kill || w_redirect) begin
                            r_state <= FETCH;
                        end else begin
                            r_instr       <= imem_rdata;
                            r_instr_pc    <= r_addr_q;
                            r_instr_valid <= 1'b1;
                            r_state       <= HOLD;
                        end
                    end else if (w_redirect) begin
                        r_kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_redirect || (r_instr_valid && instr_ready)) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase

            // Redirect overrides the sequential pc+4 and flushes the buffer.
            if (w_redirect) begin
                r_pc          <= w_target;
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = (r_state == FETCH) && rst_n;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_TRAP_PC  = 32'h0000_0000;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [31:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one request may be in flight, a one-entry buffer
    // holds the delivered instruction, and a request is only offered when
    // nothing is in flight and the buffer is empty.
    logic [31:0] m_pc, m_inflight_addr, m_buf_instr, m_buf_pc;
    logic        m_inflight, m_discard, m_buf_full;

    always @(posedge clk or negedge rst_n) begin
        logic        redir;
        logic [31:0] tgt;
        if (!rst_n) begin
            m_pc = C_RESET_PC; m_inflight = 0; m_discard = 0; m_inflight_addr = 0;
            m_buf_full = 0; m_buf_instr = 0; m_buf_pc = 0;
        end else begin
            redir = trap | redirect_valid;
            tgt   = trap ? C_TRAP_PC : (redirect_pc & 32'hFFFF_FFFC);
            if (m_inflight) begin
                if (imem_rvalid) begin
                    if (!m_discard && !redir) begin
                        m_buf_full = 1; m_buf_instr = imem_rdata; m_buf_pc = m_inflight_addr;
                    end
                    m_inflight = 0; m_discard = 0;
                end else if (redir) begin
                    m_discard = 1;
                end
            end else if (m_buf_full) begin
                if (instr_ready) m_buf_full = 0;
            end else if (imem_gnt) begin
                m_inflight = 1; m_inflight_addr = m_pc; m_pc = m_pc + 32'd4; m_discard = redir;
            end
            if (redir) begin
                m_pc = tgt; m_buf_full = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("imem_req",    {31'd0, imem_req},    {31'd0, rst_n && !m_inflight && !m_buf_full});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("pc",          pc,                   m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_buf_full});
        chk("instr",       instr,                m_buf_instr);
        chk("instr_pc",    instr_pc,             m_buf_pc);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Grant after gnt_delay idle cycles, then respond one cycle later.
    task automatic fetch_one(input logic [31:0] data, input int gnt_delay);
        for (int i = 0; i < gnt_delay; i++) cyc();
        imem_gnt = 1; cyc(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = data; cyc(); imem_rvalid = 0;
    endtask

    task automatic accept();
        instr_ready = 1; cyc(); instr_ready = 0;
    endtask

    initial begin
        logic [31:0] words [3];
        logic [31:0] held_instr, held_pc;
        words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0020_8113;

        cyc(); cyc();
        chk("rst_req_low", {31'd0, imem_req}, 32'd0);
        rst_n = 1; cyc();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);

        // Sequential fetch of 0x0, 0x4, 0x8
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, 32'(i * 4));
            fetch_one(words[i], 1);
            chk("seq_instr_pc", instr_pc, 32'(i * 4));
            chk("seq_instr", instr, words[i]);
            chk("seq_valid", {31'd0, instr_valid}, 32'd1);
            accept();
        end

        // Redirect while holding an instruction
        fetch_one(32'h1111_1111, 0);
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        redirect_valid = 1; redirect_pc = 32'h0000_0103; instr_ready = 1; cyc();
        redirect_valid = 0; instr_ready = 0;
        chk("redir_hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_hold_addr", imem_addr, 32'h0000_0100);
        chk("redir_hold_req", {31'd0, imem_req}, 32'd1);

        // Redirect while waiting: the returning response is discarded
        imem_gnt = 1; cyc(); imem_gnt = 0;
        redirect_valid = 1; redirect_pc = 32'h40; cyc(); redirect_valid = 0;
        chk("redir_wait_pc", pc, 32'h40);
        chk("redir_wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; cyc(); imem_rvalid = 0;
        chk("kill_valid", {31'd0, instr_valid}, 32'd0);
        chk("kill_addr", imem_addr, 32'h40);
        chk("kill_req", {31'd0, imem_req}, 32'd1);

        // Trap beats a simultaneous redirect
        redirect_valid = 1; redirect_pc = 32'h20; cyc();
        chk("pre_trap_pc", pc, 32'h20);
        trap = 1; redirect_pc = 32'h80; cyc(); trap = 0; redirect_valid = 0;
        chk("trap_pc", pc, 32'h0);

        // PC wrap at the top of the address space
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; cyc(); redirect_valid = 0;
        imem_gnt = 1; cyc(); imem_gnt = 0;
        chk("wrap_pc", pc, 32'h0);
        imem_rvalid = 1; imem_rdata = 32'hCAFE_0001; cyc(); imem_rvalid = 0;
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        accept();

        // Redirect coincident with a grant: the granted request is stale
        redirect_valid = 1; redirect_pc = 32'h200; imem_gnt = 1; cyc();
        redirect_valid = 0; imem_gnt = 0;
        chk("gnt_redir_pc", pc, 32'h200);
        chk("gnt_redir_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'h2222_2222; cyc(); imem_rvalid = 0;
        chk("gnt_redir_drop", {31'd0, instr_valid}, 32'd0);

        // Redirect coincident with the response
        imem_gnt = 1; cyc(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h3333_3333; redirect_valid = 1; redirect_pc = 32'h300; cyc();
        imem_rvalid = 0; redirect_valid = 0;
        chk("rv_redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("rv_redir_req", {31'd0, imem_req}, 32'd1);
        chk("rv_redir_pc", pc, 32'h300);

        // Decode stall holds the buffer steady and suppresses requests
        fetch_one(32'h4444_4444, 0);
        held_instr = instr; held_pc = instr_pc;
        for (int i = 0; i < 5; i++) begin
            imem_gnt = 1; cyc(); imem_gnt = 0;
            chk("stall_instr", instr, 32'h4444_4444);
            chk("stall_pc", instr_pc, 32'h300);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        accept();

        // Asynchronous reset mid-wait, then a stale response
        imem_gnt = 1; cyc(); imem_gnt = 0;
        #2 rst_n = 0; #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_instr_pc", instr_pc, 32'h0);
        cyc(); rst_n = 1;
        imem_rvalid = 1; imem_rdata = 32'h5555_5555; cyc(); imem_rvalid = 0;
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("stale_req", {31'd0, imem_req}, 32'd1);
        chk("stale_pc", pc, 32'h0);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Owns the architectural PC register and sequences instruction fetch over a request/grant/response instruction-memory port.
- Applies the redirect target and redirect strobe produced by the next-PC/branch logic, plus the invalid-instruction trap.
- Delivers one fetched instruction and its PC to decode through a valid/ready handshake.
- Sits between the next-PC logic, instruction memory and decode; allows one outstanding fetch at a time.

Parameters:
- XLEN, 32, PC and address width
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- TRAP_PC, 32'h0000_0000, PC value loaded on trap

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset; asynchronous assert, active-low
- redirect_valid  in  1  branch/jump taken strobe (PCsrc)
- redirect_pc  in  XLEN  redirect target (PC_next)
- trap  in  1  invalid-instruction trap request
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  fetch response valid
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instruction buffer holds a valid instruction
- instr  out  32  buffered instruction
- instr_pc  out  XLEN  PC of the buffered instruction
- instr_ready  in  1  decode accepts the instruction
- pc  out  XLEN  next fetch address (architectural PC)

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - pc=RESET_PC, state=FETCH, kill=0
  - instr_valid=0, instr=0, instr_pc=0, internal addr_q=0
- imem_req is combinational and equals (state==FETCH) with rst_n high; imem_addr=pc.
- State FETCH: on imem_gnt:
  - addr_q<=pc
  - pc<=pc+4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0)
  - go to WAIT
- State WAIT: imem_req=0; on imem_rvalid:
  - If kill=1: drop the data, kill<=0, go to FETCH.
  - Else: instr<=imem_rdata, instr_pc<=addr_q, instr_valid<=1, go to HOLD.
- State HOLD: on instr_valid&&instr_ready:
  - instr_valid<=0, go to FETCH; the request is issued the next cycle.
- Minimum fetch latency is request-to-buffer 2 cycles with a zero-wait memory; throughput is at most 1 instruction per 3 cycles.
- Redirect (redirect_valid=1 or trap=1) is sampled every cycle, in any state, and updates on the same edge:
  - pc <= TRAP_PC if trap, else {redirect_pc[XLEN-1:2],2'b00}; trap has priority over redirect_valid.
  - instr_valid<=0, so a buffered instruction is flushed even if instr_ready is high that cycle.
  - From HOLD: go to FETCH.
  - From WAIT: set kill, stay in WAIT, and drop the response when it arrives.
  - From FETCH without imem_gnt: stay in FETCH; the next request uses the new pc.
  - From FETCH with imem_gnt in the same cycle: the old-address request is in flight, so go to WAIT with kill=1. The redirected pc takes precedence over pc+4.
  - From WAIT with imem_rvalid in the same cycle: drop the response, kill<=0, go to FETCH.
- imem_rvalid outside WAIT is ignored. This covers stale responses after a reset asserted mid-WAIT.
- imem_gnt outside FETCH is ignored.
- Redirect held high for multiple cycles re-applies each cycle; the last target wins.

Decomposition:
- Package riscv_pkg holds:
  - XLEN
  - fetch_state_t enum {FETCH, WAIT, HOLD}
  - PC_STEP=4
  - RESET_PC/TRAP_PC default constants
- Single module; no sub-module. The instruction buffer is three registers and inline logic.

Test Plan:
- Reset, then gnt and rvalid each one cycle after req, with instr_ready=1 → addresses 0x0, 0x4, 0x8 are issued and instr_pc follows 0x0, 0x4, 0x8 with matching rdata.
- Redirect in HOLD with redirect_pc=0x0000_0103 → instr_valid drops the next cycle and the next imem_addr=0x0000_0100.
- Redirect to 0x40 in WAIT, then rvalid rdata=0xDEADBEEF → response dropped (instr_valid stays 0) and the next imem_addr=0x40.
- trap=1 and redirect_valid=1 (0x80) in the same cycle, with pc=0x20 → pc=TRAP_PC=0x0.
- redirect_pc=0xFFFF_FFFC, fetch granted → pc wraps to 0x0000_0000 and instr_pc=0xFFFF_FFFC.
- instr_ready held 0 for 5 cycles in HOLD → instr/instr_pc stable, imem_req=0; rst_n pulsed low mid-WAIT → all outputs zero immediately and a stale rvalid afterwards is ignored.
